// File: rtl/rom_reader_pkg.sv
// Shared definitions for the ROM burst reader: the FSM state encoding
// and the default address width.
package rom_reader_pkg;

    // Default ROM address width in bits (a 16-entry ROM).
    localparam int DEFAULT_SIZE = 4;

    // Width of one ROM word.
    localparam int DATA_W = 8;

    // Burst sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : rom_reader_pkg

// File: rtl/rom_reader_if.sv
// Signal bundle around rom_reader: the burst request, the external ROM
// port and the byte output stream.
//
// Output handshake: a byte transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_data stays stable and
// out_valid stays high until that transfer happens. out_ready may change
// at any time and has no effect while out_valid is low.
interface rom_reader_if
    import rom_reader_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) ();

    // Burst request
    logic              start;
    logic [SIZE-1:0]   base_addr;
    logic [SIZE:0]     count;

    // External ROM port
    logic              E;
    logic [SIZE-1:0]   addr;
    logic [DATA_W-1:0] data;

    // Byte output stream
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Status
    logic              busy;
    logic              done;

    // Reader side: drives the ROM port, the byte stream and the status.
    modport master (
        input  start, base_addr, count, data, out_ready,
        output E, addr, out_data, out_valid, busy, done
    );

    // Environment side: requester, ROM and byte consumer.
    modport slave (
        output start, base_addr, count, data, out_ready,
        input  E, addr, out_data, out_valid, busy, done
    );

endinterface : rom_reader_if

// File: rtl/rom_reader.sv
// Burst reader for an external combinational ROM. A request names a base
// address and a byte count. Each byte is read in one READ cycle. It is then
// held in out_data until the consumer takes it, and only then is the next
// byte read. Addresses wrap modulo 2**SIZE. A one-cycle done pulse marks the
// end of every burst, including an empty burst (count = 0).
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIZE-1:0]   base_addr,
    input  logic [SIZE:0]     count,
    output logic              E,
    output logic [SIZE-1:0]   addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    state_t              state_q,     state_d;
    logic [SIZE-1:0]     addr_q,      addr_d;
    logic [SIZE:0]       remaining_q, remaining_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic                out_valid_q, out_valid_d;

    // Next state and datapath updates; everything holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                // An empty request still ends with a done pulse but never touches the ROM.
                if (start) begin
                    if (count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = count;
                        state_d     = ST_READ;
                    end else begin
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_READ: begin
                // The ROM is enabled for this cycle only; capture its word at the edge.
                out_data_d  = data;
                out_valid_d = 1'b1;
                remaining_d = remaining_q - (SIZE+1)'(1);
                state_d     = ST_HOLD;
            end

            ST_HOLD: begin
                // Wait for the consumer; the next read starts only after a transfer.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        // Natural SIZE-bit overflow gives the wrap from max address to 0.
                        addr_d  = addr_q + SIZE'(1);
                        state_d = ST_READ;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign E         = (state_q == ST_READ);
    assign addr      = addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule : rom_reader

// File: tb/tb_rom_reader.sv
// Bench for rom_reader with SIZE=4. The external ROM returns 8'h10 + addr
// while E is high and 8'h00 otherwise. When a burst is issued, its expected
// ROM addresses and output bytes are pushed into queues. A negedge monitor
// pops and compares them whenever the DUT reads the ROM or hands over a byte.
module tb_rom_reader;
    import rom_reader_pkg::*;

    localparam int SIZE  = 4;
    localparam int DEPTH = 1 << SIZE;

    // ---------------- clock / reset ----------------
    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    rom_reader_if #(.SIZE(SIZE)) rif ();

    // External ROM model.
    assign rif.data = rif.E ? (8'h10 + {4'b0000, rif.addr}) : 8'h00;

    rom_reader #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (rif.start),
        .base_addr (rif.base_addr),
        .count     (rif.count),
        .E         (rif.E),
        .addr      (rif.addr),
        .data      (rif.data),
        .out_data  (rif.out_data),
        .out_valid (rif.out_valid),
        .out_ready (rif.out_ready),
        .busy      (rif.busy),
        .done      (rif.done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0]      exp_q[$];
    logic [SIZE-1:0] exp_addr_q[$];
    int n_cmp;
    int n_err;
    int done_exp;
    int done_seen;
    int ready_mode;   // 0: always ready, 1: random, 2: never ready

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        rif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rif.out_ready = 1'b1;
                1:       rif.out_ready = 1'($urandom_range(0, 1));
                default: rif.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic       prev_stall;
        logic       prev_done;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rif.E) begin
                    if (exp_addr_q.size() == 0) fail_now("unexpected_rom_read", 32'(rif.addr), 32'hffff);
                    else chk("rom_addr", 32'(rif.addr), 32'(exp_addr_q.pop_front()));
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(rif.out_valid), 1);
                    chk("stall_data", 32'(rif.out_data), 32'(prev_data));
                    chk("stall_e", 32'(rif.E), 0);
                end
                if (rif.out_valid && rif.out_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_byte", 32'(rif.out_data), 32'hffff);
                    else chk("out_data", 32'(rif.out_data), 32'(exp_q.pop_front()));
                end
                if (rif.done) begin
                    if (prev_done) fail_now("done_width", 2, 1);
                    done_seen++;
                end
                prev_stall = rif.out_valid && !rif.out_ready;
                prev_data  = rif.out_data;
                prev_done  = rif.done;
            end else begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue a burst from IDLE and push its expected reads and bytes.
    task automatic issue(input int base, input int n);
        int a;
        @(posedge clk);
        #1;
        rif.start     = 1'b1;
        rif.base_addr = SIZE'(base);
        rif.count     = (SIZE+1)'(n);
        for (int i = 0; i < n; i++) begin
            a = (base + i) % DEPTH;
            exp_addr_q.push_back(SIZE'(a));
            exp_q.push_back(8'(8'h10 + a));
        end
        done_exp++;
        @(posedge clk);
        #1;
        rif.start     = 1'b0;
        rif.base_addr = SIZE'($urandom);
        rif.count     = (SIZE+1)'($urandom);
    endtask

    // Follow a burst until busy drops. It checks first-read/first-byte timing,
    // optionally the 2n+1 busy length, the done count and queue drain. It can
    // inject a stray start at busy cycle inject_at, and it can release a stalled
    // consumer release_after cycles after the first byte appears.
    task automatic wait_burst(input int n, input bit tp, input int inject_at, input int release_after);
        int  busy_cyc;
        int  first_e;
        int  first_v;
        bit  ended;
        busy_cyc = 0;
        first_e  = -1;
        first_v  = -1;
        ended    = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!rif.busy) begin
                rif.start = 1'b0;
                ended = 1'b1;
                break;
            end
            busy_cyc++;
            if (rif.E && first_e < 0) first_e = busy_cyc;
            if (rif.out_valid && first_v < 0) first_v = busy_cyc;
            if (busy_cyc == inject_at) begin
                rif.start     = 1'b1;
                rif.base_addr = SIZE'(9);
                rif.count     = (SIZE+1)'(7);
            end else begin
                rif.start     = 1'b0;
            end
            if (release_after >= 0 && first_v >= 0 && busy_cyc - first_v == release_after)
                ready_mode = 0;
        end
        if (!ended) fail_now("burst_timeout", 32'(busy_cyc), 32'(2 * n + 1));
        if (n > 0) begin
            chk("first_e_cycle", 32'(first_e), 1);
            chk("first_valid_cycle", 32'(first_v), 2);
        end else begin
            chk("empty_no_read", 32'(first_e), 32'hffffffff);
            chk("empty_no_valid", 32'(first_v), 32'hffffffff);
        end
        if (tp) chk("busy_cycles", 32'(busy_cyc), 32'(2 * n + 1));
        chk("done_count", 32'(done_seen), 32'(done_exp));
        chk("bytes_left", 32'(exp_q.size()), 0);
        chk("reads_left", 32'(exp_addr_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_E"},         32'(rif.E), 0);
        chk({tag, "_addr"},      32'(rif.addr), 0);
        chk({tag, "_out_data"},  32'(rif.out_data), 0);
        chk({tag, "_out_valid"}, 32'(rif.out_valid), 0);
        chk({tag, "_busy"},      32'(rif.busy), 0);
        chk({tag, "_done"},      32'(rif.done), 0);
        chk({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;
        int mode;
        int inj;
        int waited;
        n_cmp         = 0;
        n_err         = 0;
        done_exp      = 0;
        done_seen     = 0;
        ready_mode    = 0;
        rst_n         = 1'b0;
        rif.start     = 1'b1;   // reset must win over start
        rif.base_addr = SIZE'(5);
        rif.count     = (SIZE+1)'(3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rif.start = 1'b0;
        rst_n     = 1'b1;

        // Basic burst, always ready.
        issue(2, 3);
        wait_burst(3, 1'b1, -1, -1);

        // Address wrap.
        issue(14, 4);
        wait_burst(4, 1'b1, -1, -1);

        // Consumer stalls for several cycles on the first byte.
        ready_mode = 2;
        issue(0, 2);
        wait_burst(2, 1'b0, -1, 5);
        ready_mode = 0;

        // Empty burst.
        issue(7, 0);
        wait_burst(0, 1'b1, -1, -1);

        // Stray start mid-burst is ignored.
        issue(4, 3);
        wait_burst(3, 1'b1, 3, -1);

        // Full-ROM burst starting mid-range.
        issue(11, DEPTH);
        wait_burst(DEPTH, 1'b1, -1, -1);

        // Reset during HOLD of a count=5 burst.
        ready_mode = 2;
        issue(3, 5);
        waited = 0;
        while (!rif.out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rif.out_valid) fail_now("hold_timeout", 0, 1);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        rif.start = 1'b1;   // must be ignored under reset
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_addr_q.delete();
        done_exp--;         // aborted burst produces no done
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rif.start  = 1'b0;
        rst_n      = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        chk("no_done_after_abort", 32'(done_seen), 32'(done_exp));
        issue(9, 3);
        wait_burst(3, 1'b1, -1, -1);

        // Randomized bursts.
        for (int k = 0; k < 20; k++) begin
            base = $urandom_range(0, DEPTH - 1);
            n    = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, DEPTH);
            mode = $urandom_range(0, 1);
            inj  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * n + 1) : -1;
            ready_mode = mode;
            issue(base, n);
            wait_burst(n, (mode == 0), inj, -1);
        end

        ready_mode = 0;
        repeat (3) @(negedge clk);
        chk("final_done_count", 32'(done_seen), 32'(done_exp));
        chk("final_bytes_left", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule : tb_rom_reader
